// File: rtl/tape_pkg.sv
// Shared tape definitions: character width, one-hot state indices and default timeout.
package tape_pkg;

  localparam int CHAR_W          = 5;
  localparam int TIMEOUT_DEFAULT = 1024;

  localparam int ST_IDLE = 0;
  localparam int ST_REQ  = 1;
  localparam int ST_REL  = 2;
  localparam int ST_DONE = 3;
  localparam int ST_ERR  = 4;
  localparam int NUM_ST  = 5;

  typedef enum logic [NUM_ST-1:0] {
    S_IDLE = NUM_ST'(1 << ST_IDLE),
    S_REQ  = NUM_ST'(1 << ST_REQ),
    S_REL  = NUM_ST'(1 << ST_REL),
    S_DONE = NUM_ST'(1 << ST_DONE),
    S_ERR  = NUM_ST'(1 << ST_ERR)
  } state_t;

endpackage

// File: rtl/tape_word_assembler_if.sv
// Reader-side and CPU-side handshakes of the word assembler; master is the assembler.
interface tape_word_assembler_if #(
  parameter int CHARS_PER_WORD = 7
);
  import tape_pkg::*;

  localparam int WORD_W = CHAR_W * CHARS_PER_WORD;

  logic              word_req;
  logic              input_rdy;
  logic              input_val;
  logic [CHAR_W-1:0] input_data;
  logic              word_val;
  logic [WORD_W-1:0] word_data;
  logic              word_ack;
  logic              busy;
  logic              tape_err;

  modport master (
    input  word_req, input_val, input_data, word_ack,
    output input_rdy, word_val, word_data, busy, tape_err
  );

  modport slave (
    output word_req, input_val, input_data, word_ack,
    input  input_rdy, word_val, word_data, busy, tape_err
  );

endinterface

// File: rtl/tape_timeout_cnt.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module tape_timeout_cnt #(
  parameter int CNT_W    = 10,
  parameter int LOAD_VAL = 1023
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/tape_word_assembler.sv
// Packs CHARS_PER_WORD tape characters (first in MSBs) into one word, >=4 cycles per character.
// Word is held until word_ack; TAPE_TIMEOUT_EN adds a REQ watchdog that parks the FSM in ERR.
module tape_word_assembler
  import tape_pkg::*;
#(
  parameter int CHARS_PER_WORD = 7,
  parameter int TIMEOUT        = TIMEOUT_DEFAULT
) (
  input logic                   clk,
  input logic                   resetn,
  tape_word_assembler_if.master bus
);

  localparam int WORD_W = CHAR_W * CHARS_PER_WORD;
  localparam int CNT_W  = $clog2(CHARS_PER_WORD + 1);

  if (CHARS_PER_WORD < 1) begin : g_bad_cpw
    $error("CHARS_PER_WORD must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t            state;
  logic              input_rdy_q;
  logic              word_val_q;
  logic              busy_q;
  logic [WORD_W-1:0] word_data_q;
  logic [CNT_W-1:0]  char_cnt;

`ifdef TAPE_TIMEOUT_EN
  logic tape_err_q;
  logic timed_out;

  // Reloads whenever the FSM is outside REQ, so each REQ visit gets a full window.
  tape_timeout_cnt #(
    .CNT_W   ($clog2(TIMEOUT + 1)),
    .LOAD_VAL(TIMEOUT - 1)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .load   (state != S_REQ),
    .dec    (state == S_REQ),
    .expired(timed_out)
  );

  assign bus.tape_err = tape_err_q;
`else
  assign bus.tape_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      input_rdy_q <= 1'b0;
      word_val_q  <= 1'b0;
      busy_q      <= 1'b0;
      word_data_q <= '0;
      char_cnt    <= '0;
`ifdef TAPE_TIMEOUT_EN
      tape_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          char_cnt    <= '0;
          word_data_q <= '0;
          if (bus.word_req) begin
            state       <= S_REQ;
            input_rdy_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.input_val) begin
            word_data_q <= (word_data_q << CHAR_W) | WORD_W'(bus.input_data);
            char_cnt    <= char_cnt + CNT_W'(1);
            input_rdy_q <= 1'b0;
            state       <= S_REL;
          end
`ifdef TAPE_TIMEOUT_EN
          else if (timed_out) begin
            input_rdy_q <= 1'b0;
            tape_err_q  <= 1'b1;
            state       <= S_ERR;
          end
`endif
        end
        // rdy stays low until the reader has dropped val, so no character is taken twice.
        S_REL: begin
          if (!bus.input_val) begin
            if (char_cnt == CNT_W'(CHARS_PER_WORD)) begin
              word_val_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              input_rdy_q <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_DONE: begin
          if (bus.word_ack) begin
            word_val_q <= 1'b0;
            busy_q     <= 1'b0;
            state      <= S_IDLE;
          end
        end
`ifdef TAPE_TIMEOUT_EN
        S_ERR: begin
        end
`endif
        default: begin
          state       <= S_IDLE;
          input_rdy_q <= 1'b0;
          word_val_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.input_rdy = input_rdy_q;
  assign bus.word_val  = word_val_q;
  assign bus.word_data = word_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tape_word_assembler.sv
// Scoreboarded bench: reader BFM with 2-cycle rdy->val delay, CPU driver, word monitor.
module tb_tape_word_assembler;
  import tape_pkg::*;

  localparam int CPW    = 7;
  localparam int WORD_W = CHAR_W * CPW;
`ifdef TAPE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = TIMEOUT_DEFAULT;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tape_word_assembler_if #(.CHARS_PER_WORD(CPW)) bus();

  tape_word_assembler #(.CHARS_PER_WORD(CPW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [CHAR_W-1:0] tape[0:1023];
  int tp = 0;
  int extra_hold = 0;
  bit bfm_mute = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: the word is the next CPW tape characters, first one most significant.
  function automatic logic [WORD_W-1:0] pack_word(input int start);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < CPW; i++) w = w * 32 + WORD_W'(tape[start + i]);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_input_rdy"}, bus.input_rdy, 0);
    chk({tag, "_word_val"},  bus.word_val,  0);
    chk({tag, "_word_data"}, bus.word_data, 0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_tape_err"},  bus.tape_err,  0);
  endtask

  // Reader model: val follows rdy by two edges, drops one edge (plus extra_hold) after rdy falls.
  initial begin : bfm
    int bst;
    int hold;
    bst = 0;
    hold = 0;
    bus.input_val  = 1'b0;
    bus.input_data = '0;
    forever begin
      tick();
      if (!resetn) begin
        bst = 0;
        bus.input_val = 1'b0;
      end else begin
        case (bst)
          0: if (bus.input_rdy && !bfm_mute) bst = 1;
          1: begin
            bus.input_val  = 1'b1;
            bus.input_data = tape[tp];
            tp++;
            bst = 2;
          end
          2: if (!bus.input_rdy) begin
            hold = extra_hold;
            bst = 3;
          end
          default: begin
            if (hold == 0) begin
              bus.input_val = 1'b0;
              bst = 0;
            end else begin
              hold--;
            end
          end
        endcase
      end
    end
  end

  initial begin : monitor
    logic prev_wv;
    logic prev_rdy;
    logic [WORD_W-1:0] held;
    prev_wv = 1'b0;
    prev_rdy = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_wv = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (bus.word_val && !prev_wv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=0x%0h required=no word", bus.word_data);
          end else begin
            held = exp_q.pop_front();
            chk("word_data", bus.word_data, held);
          end
        end else if (bus.word_val) begin
          chk("word_hold", bus.word_data, held);
          chk("rdy_in_done", bus.input_rdy, 0);
        end
        if (bus.input_rdy && !prev_rdy) chk("rdy_rise_val_low", bus.input_val, 0);
        prev_wv = bus.word_val;
        prev_rdy = bus.input_rdy;
      end
    end
  end

  task automatic get_word(input int stall, input int hold, input bit poke,
                          input bit fixed, input logic [WORD_W-1:0] fexp);
    int n;
    extra_hold = hold;
    exp_q.push_back(fixed ? fexp : pack_word(tp));
    bus.word_req = 1'b1;
    tick();
    bus.word_req = 1'b0;
    chk("busy_after_req", bus.busy, 1);
    if (poke) begin
      bus.word_req = 1'b1;
      tick();
      bus.word_req = 1'b0;
    end
    n = 0;
    while (!bus.word_val && n < 400) begin
      tick();
      n++;
    end
    if (!bus.word_val) begin
      checks++;
      errors++;
      $display("FAIL word_val_timeout actual=0 required=1 after %0d cycles", n);
      return;
    end
    if (poke) begin
      bus.word_req = 1'b1;
      tick();
      bus.word_req = 1'b0;
    end
    repeat (stall) tick();
    bus.word_ack = 1'b1;
    bus.word_req = poke;
    tick();
    bus.word_ack = 1'b0;
    bus.word_req = 1'b0;
    chk("word_val_after_ack", bus.word_val, 0);
    chk("busy_after_ack", bus.busy, 0);
    if (poke) begin
      repeat (10) tick();
      chk("no_extra_word_busy", bus.busy, 0);
    end
  endtask

  initial begin : main
    int start;
    int n;
    bus.word_req = 1'b0;
    bus.word_ack = 1'b0;
    for (int i = 0; i < 1024; i++)
      tape[i] = (i < 7) ? CHAR_W'(i + 1) : CHAR_W'($urandom_range(0, 31));

    resetn = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    get_word(2, 0, 1'b0, 1'b1, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7});
    get_word(20, 0, 1'b0, 1'b0, '0);
    get_word(0, 3, 1'b0, 1'b0, '0);
    get_word(1, 0, 1'b1, 1'b0, '0);
    get_word(0, 0, 1'b0, 1'b0, '0);

    // Abort after the third character; no word may follow for that request.
    start = tp;
    extra_hold = 0;
    bus.word_req = 1'b1;
    tick();
    bus.word_req = 1'b0;
    n = 0;
    while (tp < start + 3 && n < 200) begin
      tick();
      n++;
    end
    chk("third_char_reached", tp - start, 3);
    repeat (2) tick();
    resetn = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("midword_reset");
    resetn = 1'b1;
    repeat (100) tick();
    chk("no_partial_word_val", bus.word_val, 0);
    chk("no_partial_busy", bus.busy, 0);

    for (int k = 0; k < 12; k++)
      get_word($urandom_range(0, 5), $urandom_range(0, 3), 1'b0, 1'b0, '0);

`ifdef TAPE_TIMEOUT_EN
    bfm_mute = 1'b1;
    bus.word_req = 1'b1;
    tick();
    bus.word_req = 1'b0;
    for (int j = 1; j <= TO; j++) begin
      tick();
      chk("tape_err_timing", bus.tape_err, (j == TO) ? 1 : 0);
    end
    chk("err_input_rdy", bus.input_rdy, 0);
    chk("err_busy", bus.busy, 1);
    chk("err_word_val", bus.word_val, 0);
    resetn = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("err_reset");
    resetn = 1'b1;
    bfm_mute = 1'b0;
    tick();
`endif

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
